// File: rtl/cdc_tx_pkg.sv
// Shared types and sizing helpers for the CDC transfer scheduler.
package cdc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } cdc_tx_state_e;

  // One counter serves both windows, so it must hold the larger of the two.
  function automatic int cdc_cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// Combinational rotating-priority picker; search starts one past ptr_i.
// With CDC_TX_FIXED_PRIO_EN defined it becomes a lowest-index-wins encoder.
module cdc_rr_pick
  import cdc_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef CDC_TX_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr_i,
`endif
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

`ifdef CDC_TX_FIXED_PRIO_EN
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
        any_o      = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int cand;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
        any_o         = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cdc_tx_scheduler.sv
// Shares one bus/enable CDC path among NUM_REQ requesters with fixed HOLD/GAP windows.
// Define CDC_TX_FIXED_PRIO_EN for fixed priority instead of round-robin.
module cdc_tx_scheduler
  import cdc_tx_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic [BUS_WIDTH-1:0]           Unsync_bus,
  output logic                           bus_enable
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cdc_cnt_width(HOLD_CYCLES, GAP_CYCLES);

  cdc_tx_state_e        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 en_q, en_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [IDX_W-1:0]     gid_q, gid_d;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
`ifndef CDC_TX_FIXED_PRIO_EN
  logic [IDX_W-1:0]     ptr_q, ptr_d;
`endif

  cdc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req),
`ifndef CDC_TX_FIXED_PRIO_EN
    .ptr_i   (ptr_q),
`endif
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    ack_d   = '0;
    gid_d   = gid_q;
`ifndef CDC_TX_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) bus_d = req_data[i*BUS_WIDTH +: BUS_WIDTH];
          end
          en_d    = 1'b1;
          ack_d   = pick_grant;
          gid_d   = pick_idx;
`ifndef CDC_TX_FIXED_PRIO_EN
          ptr_d   = pick_idx;
`endif
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        // The extra IDLE cycle after the gap sets the H+G+1 edge spacing.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= '0;
      gid_q   <= '0;
`ifndef CDC_TX_FIXED_PRIO_EN
      ptr_q   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
`ifndef CDC_TX_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign grant_id   = gid_q;
  assign busy       = (state_q != IDLE);
  assign Unsync_bus = bus_q;
  assign bus_enable = en_q;

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Self-checking bench for cdc_tx_scheduler: default 4/8/4/4 instance plus a HOLD=GAP=1 instance.
module tb_cdc_tx_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  Unsync_bus;
  logic        bus_enable;

  logic [3:0]  reqS;
  logic [31:0] dataS;
  logic [3:0]  ackS;
  logic [1:0]  gidS;
  logic        busyS;
  logic [7:0]  busS;
  logic        enS;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 CLK = ~CLK;

  cdc_tx_scheduler #(.NUM_REQ(4), .BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .ack(ack), .grant_id(grant_id),
    .busy(busy), .Unsync_bus(Unsync_bus), .bus_enable(bus_enable)
  );

  cdc_tx_scheduler #(.NUM_REQ(4), .BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dutShort (
    .CLK(CLK), .RST(RST), .req(reqS), .req_data(dataS), .ack(ackS), .grant_id(gidS),
    .busy(busyS), .Unsync_bus(busS), .bus_enable(enS)
  );

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = '0;
    reqS = '0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic wait_ack(input int limit, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (n < limit && !ok) begin
      step();
      n++;
      if (ack !== 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (n < 30 && !ok) begin
      step();
      n++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; req = '0; reqS = '0; req_data = '0; dataS = '0;
    step();
    step();
    checks++; if (bus_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_en got %b want 0", bus_enable); end
    checks++; if (Unsync_bus !== 8'h00) begin fails++; $display("[TB] FAIL reset_bus got %h want 00", Unsync_bus); end
    checks++; if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL reset_ack got %b want 0000", ack); end
    checks++; if (grant_id !== 2'd0) begin fails++; $display("[TB] FAIL reset_gid got %0d want 0", grant_id); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (enS !== 1'b0) begin fails++; $display("[TB] FAIL reset_en_short got %b want 0", enS); end
    RST = 1'b0;
  endtask

  task automatic test_single();
    bit ok; int n; int enHi; int busyHi; int extraAck; exp_t e;
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    sbq.push_back('{id: 2'd0, data: 8'hA5});
    wait_ack(5, ok, n);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL single_ack_timeout got none want ack"); end
    checks++; if (n !== 1) begin fails++; $display("[TB] FAIL single_latency got %0d want 1", n); end
    if (ok && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (ack !== (4'b0001 << e.id)) begin fails++; $display("[TB] FAIL single_ack got %b want %b", ack, 4'b0001 << e.id); end
      checks++; if (grant_id !== e.id) begin fails++; $display("[TB] FAIL single_gid got %0d want %0d", grant_id, e.id); end
      checks++; if (Unsync_bus !== e.data) begin fails++; $display("[TB] FAIL single_bus got %h want %h", Unsync_bus, e.data); end
    end
    req = '0;
    enHi = int'(bus_enable); busyHi = int'(busy); extraAck = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      enHi += int'(bus_enable);
      busyHi += int'(busy);
      if (ack !== 4'b0000) extraAck++;
    end
    checks++; if (enHi !== 4) begin fails++; $display("[TB] FAIL single_en_cycles got %0d want 4", enHi); end
    checks++; if (busyHi !== 8) begin fails++; $display("[TB] FAIL single_busy_cycles got %0d want 8", busyHi); end
    checks++; if (extraAck !== 0) begin fails++; $display("[TB] FAIL single_extra_ack got %0d want 0", extraAck); end
  endtask

  task automatic test_round_robin();
    int total; int got; int prevAck; logic prevEn; bit ok; exp_t e;
    do_reset();
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
`ifdef CDC_TX_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) sbq.push_back('{id: 2'd0, data: 8'h10});
`else
    for (int i = 0; i < 5; i++) sbq.push_back('{id: 2'(i % 4), data: 8'(8'h10 * ((i % 4) + 1))});
`endif
    req = 4'b1111;
    total = 0; got = 0; prevAck = 0; prevEn = bus_enable;
    while (got < 5 && total < 80) begin
      step();
      total++;
      if (ack !== 4'b0000 && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++; if (grant_id !== e.id) begin fails++; $display("[TB] FAIL rr_gid[%0d] got %0d want %0d", got, grant_id, e.id); end
        checks++; if (ack !== (4'b0001 << e.id)) begin fails++; $display("[TB] FAIL rr_ack[%0d] got %b want %b", got, ack, 4'b0001 << e.id); end
        checks++; if (Unsync_bus !== e.data) begin fails++; $display("[TB] FAIL rr_bus[%0d] got %h want %h", got, Unsync_bus, e.data); end
        checks++; if (!(bus_enable === 1'b1 && prevEn === 1'b0)) begin fails++; $display("[TB] FAIL rr_rise[%0d] got %b->%b want 0->1", got, prevEn, bus_enable); end
        if (got > 0) begin
          checks++; if (total - prevAck !== 9) begin fails++; $display("[TB] FAIL rr_spacing[%0d] got %0d want 9", got, total - prevAck); end
        end
        prevAck = total;
        got++;
      end
      prevEn = bus_enable;
    end
    checks++; if (got !== 5) begin fails++; $display("[TB] FAIL rr_count got %0d want 5", got); end
    req = '0;
    sbq.delete();
    wait_idle(ok);
  endtask

  task automatic test_late_request();
    int n; int got; int a0; bit ok; exp_t e;
    do_reset();
    req_data[7:0] = 8'h55; req_data[23:16] = 8'h77;
    sbq.push_back('{id: 2'd0, data: 8'h55});
    sbq.push_back('{id: 2'd2, data: 8'h77});
    req = 4'b0001;
    n = 0; got = 0; a0 = 0;
    while (got < 2 && n < 40) begin
      step();
      n++;
      if (ack !== 4'b0000 && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++; if (grant_id !== e.id) begin fails++; $display("[TB] FAIL late_gid[%0d] got %0d want %0d", got, grant_id, e.id); end
        checks++; if (Unsync_bus !== e.data) begin fails++; $display("[TB] FAIL late_bus[%0d] got %h want %h", got, Unsync_bus, e.data); end
        if (got == 0) begin
          a0 = n;
          req[0] = 1'b0;
        end else begin
          checks++; if (n - a0 !== 9) begin fails++; $display("[TB] FAIL late_delay got %0d want 9", n - a0); end
          req[2] = 1'b0;
        end
        got++;
      end else if (got == 1 && n == a0 + 1) begin
        req[2] = 1'b1;
      end
    end
    checks++; if (got !== 2) begin fails++; $display("[TB] FAIL late_count got %0d want 2", got); end
    req = '0;
    sbq.delete();
    wait_idle(ok);
  endtask

  task automatic test_withdraw();
    bit ok; int n; int acks; exp_t e;
    do_reset();
    req_data[7:0] = 8'h3C; req_data[15:8] = 8'h99;
    sbq.push_back('{id: 2'd0, data: 8'h3C});
    req = 4'b0001;
    wait_ack(5, ok, n);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL wd_ack_timeout got none want ack"); end
    if (ok && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (Unsync_bus !== e.data) begin fails++; $display("[TB] FAIL wd_first_bus got %h want %h", Unsync_bus, e.data); end
    end
    req = '0;
    step();
    req = 4'b0010;
    for (int k = 0; k < 4; k++) step();
    checks++; if (!(busy === 1'b1 && bus_enable === 1'b0)) begin fails++; $display("[TB] FAIL wd_in_gap got busy=%b en=%b want busy=1 en=0", busy, bus_enable); end
    req = '0;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ack !== 4'b0000) acks++;
    end
    checks++; if (acks !== 0) begin fails++; $display("[TB] FAIL wd_no_ack got %0d want 0", acks); end
    checks++; if (Unsync_bus !== 8'h3C) begin fails++; $display("[TB] FAIL wd_bus_held got %h want 3c", Unsync_bus); end
  endtask

  task automatic test_reset_mid_hold();
    bit ok; int n; exp_t e;
    do_reset();
    req_data[7:0] = 8'h11; req_data[31:24] = 8'h88;
    req = 4'b0001;
    wait_ack(5, ok, n);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL rmh_ack_timeout got none want ack"); end
    req = '0;
    step();
    RST = 1'b1;
    step();
    checks++; if (bus_enable !== 1'b0) begin fails++; $display("[TB] FAIL rmh_en got %b want 0", bus_enable); end
    checks++; if (Unsync_bus !== 8'h00) begin fails++; $display("[TB] FAIL rmh_bus got %h want 00", Unsync_bus); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rmh_busy got %b want 0", busy); end
    checks++; if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL rmh_ack got %b want 0000", ack); end
    RST = 1'b0;
    sbq.push_back('{id: 2'd3, data: 8'h88});
    req = 4'b1000;
    wait_ack(5, ok, n);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL rmh_post_timeout got none want ack"); end
    if (ok && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (grant_id !== e.id) begin fails++; $display("[TB] FAIL rmh_gid got %0d want %0d", grant_id, e.id); end
      checks++; if (ack !== 4'b1000) begin fails++; $display("[TB] FAIL rmh_post_ack got %b want 1000", ack); end
      checks++; if (Unsync_bus !== e.data) begin fails++; $display("[TB] FAIL rmh_post_bus got %h want %h", Unsync_bus, e.data); end
    end
    req = '0;
    sbq.delete();
    wait_idle(ok);
  endtask

  task automatic test_short_windows();
    int n; bit ok; logic expEn;
    dataS[7:0] = 8'hA1;
    reqS = 4'b0001;
    n = 0; ok = 1'b0;
    while (n < 5 && !ok) begin
      step();
      n++;
      if (ackS !== 4'b0000) ok = 1'b1;
    end
    checks++; if (!ok) begin fails++; $display("[TB] FAIL short_ack_timeout got none want ack"); end
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      expEn = (k % 3 == 0);
      checks++; if (enS !== expEn) begin fails++; $display("[TB] FAIL short_en[%0d] got %b want %b", k, enS, expEn); end
      checks++; if (ackS[0] !== expEn) begin fails++; $display("[TB] FAIL short_ack[%0d] got %b want %b", k, ackS[0], expEn); end
    end
    checks++; if (busS !== 8'hA1) begin fails++; $display("[TB] FAIL short_bus got %h want a1", busS); end
    reqS = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_request();
    test_withdraw();
    test_reset_mid_hold();
    test_short_windows();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
